// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the register-file operation sequencer.
//   A_AW / A_DW : register file A address / data width (8 x 4)
//   B_AW        : register file B address width (16 x 8)
//   state_t     : sequencer FSM states
//   cmd_t       : one latched operation command
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int A_AW = 3;
    localparam int A_DW = 4;
    localparam int B_AW = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WB1   = 3'd2,
        ST_WB2   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic [A_AW-1:0] ra1;
        logic [A_AW-1:0] ra2;
        logic [B_AW-1:0] rb;
        logic [A_AW-1:0] dst1;
        logic [A_AW-1:0] dst2;
        logic            wb;
    } cmd_t;

endpackage

// File: rtl/regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_op_sequencer
// Control stage in front of the register-file datapath. Accepts one command
// per valid/ready handshake, pulses dp_start for one cycle with the command's
// read addresses, captures out1/out2, optionally writes both results back to
// register file A (out1 then out2), and offers the results on a valid/ready
// result interface. Only one operation is in flight at a time.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   cmd_valid / cmd_ready     command handshake
//   cmd_ra1, cmd_ra2, cmd_rb  read addresses for the operation
//   cmd_dst1, cmd_dst2        writeback addresses for out1 / out2
//   cmd_wb                    writeback enable
//   dp_start                  one-cycle datapath start strobe
//   dp_ra1, dp_ra2, dp_rb     datapath read addresses
//   dp_out1, dp_out2          datapath results (combinational)
//   wr_en_a, wr_reg_a,
//   wr_data_a                 register file A write port
//   res_valid / res_ready     result handshake
//   res_out1, res_out2        captured results
//   op_count                  completed-operation counter (wraps)
// ---------------------------------------------------------------------------
module regfile_op_sequencer #(
    parameter int A_AW  = regfile_pkg::A_AW,
    parameter int A_DW  = regfile_pkg::A_DW,
    parameter int B_AW  = regfile_pkg::B_AW,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [A_AW-1:0]  cmd_ra1,
    input  logic [A_AW-1:0]  cmd_ra2,
    input  logic [B_AW-1:0]  cmd_rb,
    input  logic [A_AW-1:0]  cmd_dst1,
    input  logic [A_AW-1:0]  cmd_dst2,
    input  logic             cmd_wb,
    output logic             dp_start,
    output logic [A_AW-1:0]  dp_ra1,
    output logic [A_AW-1:0]  dp_ra2,
    output logic [B_AW-1:0]  dp_rb,
    input  logic [A_DW-1:0]  dp_out1,
    input  logic [A_DW-1:0]  dp_out2,
    output logic             wr_en_a,
    output logic [A_AW-1:0]  wr_reg_a,
    output logic [A_DW-1:0]  wr_data_a,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [A_DW-1:0]  res_out1,
    output logic [A_DW-1:0]  res_out2,
    output logic [CNT_W-1:0] op_count
);

    import regfile_pkg::*;

    state_t           state;
    state_t           stateNext;
    cmd_t             cmdReg;
    logic [A_DW-1:0]  out1Reg;
    logic [A_DW-1:0]  out2Reg;
    logic [CNT_W-1:0] opCount;
    logic [A_AW-1:0]  wrReg;
    logic [A_DW-1:0]  wrData;

    // Next-state logic. cmd_ready is exactly "state is IDLE", so cmd_valid
    // alone qualifies the accept here.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (cmd_valid) stateNext = ST_ISSUE;
            ST_ISSUE: stateNext = cmdReg.wb ? ST_WB1 : ST_DONE;
            ST_WB1:   stateNext = ST_WB2;
            ST_WB2:   stateNext = ST_DONE;
            ST_DONE:  if (res_ready) stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its sources.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Command, result and counter registers. The command fields change only
    // on accept, so dp_ra*/dp_rb hold their last values outside ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmdReg  <= '0;
            out1Reg <= '0;
            out2Reg <= '0;
            opCount <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                cmdReg.ra1  <= cmd_ra1;
                cmdReg.ra2  <= cmd_ra2;
                cmdReg.rb   <= cmd_rb;
                cmdReg.dst1 <= cmd_dst1;
                cmdReg.dst2 <= cmd_dst2;
                cmdReg.wb   <= cmd_wb;
            end
            // The datapath is combinational; its outputs are valid while the
            // read addresses are presented during ISSUE.
            if (state == ST_ISSUE) begin
                out1Reg <= dp_out1;
                out2Reg <= dp_out2;
            end
            if (state == ST_DONE && res_ready) begin
                opCount <= opCount + CNT_W'(1);
            end
        end
    end

    // Writeback port: out1 in WB1, out2 in WB2. With dst1 == dst2 the second
    // write lands last, so out2 is what remains in the register.
    always_comb begin
        wrReg  = '0;
        wrData = '0;
        case (state)
            ST_WB1: begin
                wrReg  = cmdReg.dst1;
                wrData = out1Reg;
            end
            ST_WB2: begin
                wrReg  = cmdReg.dst2;
                wrData = out2Reg;
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the state register and registered fields only.
    assign cmd_ready = (state == ST_IDLE);
    assign dp_start  = (state == ST_ISSUE);
    assign dp_ra1    = cmdReg.ra1;
    assign dp_ra2    = cmdReg.ra2;
    assign dp_rb     = cmdReg.rb;
    assign wr_en_a   = (state == ST_WB1) || (state == ST_WB2);
    assign wr_reg_a  = wrReg;
    assign wr_data_a = wrData;
    assign res_valid = (state == ST_DONE);
    assign res_out1  = out1Reg;
    assign res_out2  = out2Reg;
    assign op_count  = opCount;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_regfile_op_sequencer
// Directed bench for regfile_op_sequencer connected to a behavioural model of
// the register-file datapath (A: 8x4, B: 16x8, both reloaded on reset).
//   out1 = A[ra1] + B[rb][7:4]; an overflow is reported as 4'h8 (carry flag
//          in the MSB, low bits cleared)
//   out2 = max(A[ra2], B[rb][3:0])
// ---------------------------------------------------------------------------
module tb_regfile_op_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_ra1;
    logic [2:0] cmd_ra2;
    logic [3:0] cmd_rb;
    logic [2:0] cmd_dst1;
    logic [2:0] cmd_dst2;
    logic       cmd_wb;
    logic       dp_start;
    logic [2:0] dp_ra1;
    logic [2:0] dp_ra2;
    logic [3:0] dp_rb;
    logic [3:0] dp_out1;
    logic [3:0] dp_out2;
    logic       wr_en_a;
    logic [2:0] wr_reg_a;
    logic [3:0] wr_data_a;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_out1;
    logic [3:0] res_out2;
    logic [7:0] op_count;

    int nChecks = 0;
    int nErrors = 0;

    regfile_op_sequencer #(.A_AW(3), .A_DW(4), .B_AW(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ra1   (cmd_ra1),
        .cmd_ra2   (cmd_ra2),
        .cmd_rb    (cmd_rb),
        .cmd_dst1  (cmd_dst1),
        .cmd_dst2  (cmd_dst2),
        .cmd_wb    (cmd_wb),
        .dp_start  (dp_start),
        .dp_ra1    (dp_ra1),
        .dp_ra2    (dp_ra2),
        .dp_rb     (dp_rb),
        .dp_out1   (dp_out1),
        .dp_out2   (dp_out2),
        .wr_en_a   (wr_en_a),
        .wr_reg_a  (wr_reg_a),
        .wr_data_a (wr_data_a),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out1  (res_out1),
        .res_out2  (res_out2),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- datapath model ----------------
    logic [3:0] regA [8];
    logic [7:0] regB [16];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regA[i] <= 4'h0;
            for (int i = 0; i < 16; i++) regB[i] <= 8'h00;
            regA[0] <= 4'h9;
            regA[1] <= 4'h5;
            regA[3] <= 4'h2;
            regA[6] <= 4'h7;
            regB[2] <= 8'h93;
            regB[5] <= 8'h84;
            regB[7] <= 8'h15;
        end else if (wr_en_a) begin
            regA[wr_reg_a] <= wr_data_a;
        end
    end

    logic [4:0] sum;
    logic [3:0] aMax;
    logic [3:0] bLow;
    always_comb begin
        sum     = {1'b0, regA[dp_ra1]} + {1'b0, regB[dp_rb][7:4]};
        aMax    = regA[dp_ra2];
        bLow    = regB[dp_rb][3:0];
        dp_out1 = sum[4] ? 4'h8 : sum[3:0];
        dp_out2 = (aMax > bLow) ? aMax : bLow;
    end

    // Event counters observed by the stimulus block.
    int startCount = 0;
    int writeCount = 0;
    always @(posedge clk) begin
        if (dp_start) startCount++;
        if (wr_en_a)  writeCount++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a command during an IDLE cycle; returns at the ISSUE-cycle negedge.
    task automatic issue(input logic [2:0] ra1, input logic [2:0] ra2, input logic [3:0] rb,
                         input logic [2:0] d1, input logic [2:0] d2, input logic wb);
        cmd_ra1   = ra1;
        cmd_ra2   = ra2;
        cmd_rb    = rb;
        cmd_dst1  = d1;
        cmd_dst2  = d2;
        cmd_wb    = wb;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Bounded wait for res_valid, sampling on negedges.
    task automatic waitResValid(input string tag, input int budget);
        for (int k = 0; k < budget && !res_valid; k++) @(negedge clk);
        check(tag, res_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int snapStart;
    int snapWrite;

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
        cmd_ra1 = '0; cmd_ra2 = '0; cmd_rb = '0; cmd_dst1 = '0; cmd_dst2 = '0; cmd_wb = 1'b0;

        // ---- reset state ----
        #2 rst = 1'b1;
        #4;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_dp_start", dp_start, 0);
        check("rst_wr_en_a", wr_en_a, 0);
        check("rst_op_count", op_count, 0);
        check("rst_res_out1", res_out1, 0);
        check("rst_dp_ra1", dp_ra1, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- 1: no carry, no writeback ----
        res_ready = 1'b1;
        snapStart = startCount;
        snapWrite = writeCount;
        issue(3'd1, 3'd3, 4'd2, 3'd0, 3'd0, 1'b0);
        check("t1_issue_start", dp_start, 1);
        check("t1_issue_ra1", dp_ra1, 1);
        check("t1_issue_ra2", dp_ra2, 3);
        check("t1_issue_rb", dp_rb, 2);
        check("t1_issue_cmd_ready", cmd_ready, 0);
        check("t1_issue_res_valid", res_valid, 0);
        @(negedge clk);
        check("t1_latency2_res_valid", res_valid, 1);
        check("t1_res_out1", res_out1, 4'hE);
        check("t1_res_out2", res_out2, 4'h3);
        check("t1_done_start_low", dp_start, 0);
        check("t1_hold_ra1", dp_ra1, 1);
        @(negedge clk);
        check("t1_op_count", op_count, 1);
        check("t1_back_idle", cmd_ready, 1);
        check("t1_start_pulses", startCount - snapStart, 1);
        check("t1_no_writes", writeCount - snapWrite, 0);

        // ---- 2: carry plus writeback, then backpressure ----
        res_ready = 1'b0;
        issue(3'd0, 3'd6, 4'd5, 3'd4, 3'd2, 1'b1);
        check("t2_issue_start", dp_start, 1);
        @(negedge clk);
        check("t2_wb1_en", wr_en_a, 1);
        check("t2_wb1_reg", wr_reg_a, 4);
        check("t2_wb1_data", wr_data_a, 4'h8);
        check("t2_wb1_res_valid", res_valid, 0);
        @(negedge clk);
        check("t2_wb2_en", wr_en_a, 1);
        check("t2_wb2_reg", wr_reg_a, 2);
        check("t2_wb2_data", wr_data_a, 4'h7);
        check("t2_wb2_res_valid", res_valid, 0);
        @(negedge clk);
        check("t2_latency4_res_valid", res_valid, 1);
        check("t2_res_out1", res_out1, 4'h8);
        check("t2_res_out2", res_out2, 4'h7);
        check("t2_done_wr_en", wr_en_a, 0);
        check("t2_regA4", regA[4], 4'h8);
        check("t2_regA2", regA[2], 4'h7);

        // Second command pending while the first result is back-pressured.
        cmd_ra1 = 3'd4; cmd_ra2 = 3'd2; cmd_rb = 4'd7;
        cmd_dst1 = 3'd0; cmd_dst2 = 3'd0; cmd_wb = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_bp_res_valid", res_valid, 1);
            check("t3_bp_res_out1", res_out1, 4'h8);
            check("t3_bp_res_out2", res_out2, 4'h7);
            check("t3_bp_cmd_ready", cmd_ready, 0);
            check("t3_bp_op_count", op_count, 1);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("t3_idle_op_count", op_count, 2);
        check("t3_idle_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t3_second_accepted", dp_start, 1);
        check("t3_second_ra1", dp_ra1, 4);
        @(negedge clk);
        check("t3_second_res_valid", res_valid, 1);
        check("t3_second_out1_raw", res_out1, 4'h9);
        check("t3_second_out2", res_out2, 4'h7);
        @(negedge clk);
        check("t3_op_count", op_count, 3);

        // ---- 4: same destination ----
        snapWrite = writeCount;
        issue(3'd1, 3'd3, 4'd2, 3'd1, 3'd1, 1'b1);
        @(negedge clk);
        check("t4_wb1_reg", wr_reg_a, 1);
        check("t4_wb1_data", wr_data_a, 4'hE);
        @(negedge clk);
        check("t4_wb2_reg", wr_reg_a, 1);
        check("t4_wb2_data", wr_data_a, 4'h3);
        @(negedge clk);
        check("t4_res_valid", res_valid, 1);
        check("t4_res_out1", res_out1, 4'hE);
        check("t4_res_out2", res_out2, 4'h3);
        @(negedge clk);
        check("t4_op_count", op_count, 4);
        check("t4_two_writes", writeCount - snapWrite, 2);
        check("t4_regA1", regA[1], 4'h3);

        // ---- 5: reset in the middle of WB1 ----
        issue(3'd0, 3'd6, 4'd5, 3'd5, 3'd6, 1'b1);
        @(negedge clk);
        check("t5_in_wb1", wr_en_a, 1);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_wr_en", wr_en_a, 0);
        check("t5_rst_cmd_ready", cmd_ready, 1);
        check("t5_rst_res_valid", res_valid, 0);
        check("t5_rst_op_count", op_count, 0);
        @(negedge clk);
        rst = 1'b0;
        snapWrite = writeCount;
        repeat (4) @(negedge clk);
        check("t5_no_wb2", writeCount - snapWrite, 0);
        check("t5_idle_after", cmd_ready, 1);

        // ---- 6: counter wrap ----
        res_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue(3'd1, 3'd3, 4'd2, 3'd0, 3'd0, 1'b0);
            waitResValid("t6_res_valid_wait", 4);
            if (i == 255) check("t6_before_wrap", op_count, 255);
            @(negedge clk);
        end
        check("t6_after_wrap", op_count, 0);
        check("t6_idle", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Control stage directly upstream of the register-file datapath (register file A 8x4, register file B 16x8, adder on out1, max-select on out2).
- Accepts one operation command per valid/ready handshake and drives the datapath read addresses and `start` for exactly one cycle.
- Captures out1/out2, optionally writes both results back into register file A through its single write port, then presents the results on a valid/ready result interface.

Parameters:
- A_AW, 3, register file A address width.
- A_DW, 4, register file A data width, and width of out1/out2.
- B_AW, 4, register file B address width.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ra1  in  A_AW  register A read address feeding the adder.
- cmd_ra2  in  A_AW  register A read address feeding the max compare.
- cmd_rb  in  B_AW  register B read address.
- cmd_dst1  in  A_AW  writeback address for out1.
- cmd_dst2  in  A_AW  writeback address for out2.
- cmd_wb  in  1  writeback enable.
- dp_start  out  1  datapath start strobe.
- dp_ra1  out  A_AW  to datapath ReadRegA1.
- dp_ra2  out  A_AW  to datapath ReadRegA2.
- dp_rb  out  B_AW  to datapath ReadRegB.
- dp_out1  in  A_DW  datapath out1.
- dp_out2  in  A_DW  datapath out2.
- wr_en_a  out  1  register file A write enable.
- wr_reg_a  out  A_AW  register file A write address.
- wr_data_a  out  A_DW  register file A write data.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_out1  out  A_DW  captured out1.
- res_out2  out  A_DW  captured out2.
- op_count  out  CNT_W  number of completed operations.

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately on the rising edge of rst.
  - State goes to IDLE.
  - All outputs go to 0 except cmd_ready, which is 1.
  - Captured command fields, results and op_count clear to 0.
- States: IDLE, ISSUE, WB1, WB2, DONE. State is registered; all outputs are registered or decoded from state plus registered fields (no input-to-output combinational path).
- IDLE:
  - cmd_ready=1. On cmd_valid&&cmd_ready, latch all cmd_* fields and go to ISSUE.
  - Latching in this cycle does not depend on res_ready.
- ISSUE (exactly 1 cycle):
  - dp_start=1; dp_ra1/ra2/rb driven from the latched fields. The datapath is combinational.
  - At the ending edge, register dp_out1 into res_out1 and dp_out2 into res_out2.
  - Next state: WB1 if cmd_wb, else DONE.
- WB1 (1 cycle): wr_en_a=1, wr_reg_a=dst1, wr_data_a=res_out1. Next state: WB2.
- WB2 (1 cycle): wr_en_a=1, wr_reg_a=dst2, wr_data_a=res_out2. Next state: DONE.
  - If dst1==dst2, both writes still occur; the final value is out2.
- DONE:
  - res_valid=1; res_out1/res_out2 are held stable while res_valid=1.
  - On res_ready, go to IDLE and increment op_count (wraps modulo 2^CNT_W).
- dp_start is 0 and dp_ra*/dp_rb hold their last values in every state except ISSUE.
- wr_en_a is 0 outside WB1/WB2.
- Latency from accept edge to res_valid:
  - 2 cycles with cmd_wb=0.
  - 4 cycles with cmd_wb=1.
- Throughput: at most one operation in flight. cmd_ready=0 from ISSUE through DONE, so a later command always reads post-writeback register contents and there are no read-after-write hazards.
- res_ready asserted while res_valid=0 has no effect.
- cmd_valid held high during a busy period has no effect; that command is accepted on the next IDLE cycle.
- Reset mid-operation:
  - The operation is abandoned and op_count is not incremented.
  - Any write not yet issued is not issued; a write already performed in WB1 is not undone.
  - The datapath register files reload their own initial contents on the same reset.

Decomposition:
- Shared package `regfile_pkg`:
  - Width constants A_AW=3, A_DW=4, B_AW=4.
  - State enum for IDLE/ISSUE/WB1/WB2/DONE.
  - Packed command struct {ra1, ra2, rb, dst1, dst2, wb}.
- No sub-module: a single FSM plus capture registers. The bench instantiates this block together with the register-file datapath.

Test Plan:
- No carry. Preload A[1]=5, B[2]=0x93, A[3]=2. Command ra1=1, ra2=3, rb=2, wb=0, res_ready=1.
  - Expected: dp_start high exactly 1 cycle; res_valid 2 cycles after accept.
  - Results: res_out1=0xE (5+9), res_out2=3 (max(2,3)); op_count=1; wr_en_a never asserted.
- Carry plus writeback. A[0]=9, B[5]=0x84, A[6]=7. Command ra1=0, ra2=6, rb=5, dst1=4, dst2=2, wb=1.
  - Expected: res_out1=0x8 (9+8=17, carry: {1,000}); res_out2=7.
  - Writes: WB1 writes A[4]=8, WB2 writes A[2]=7; res_valid 4 cycles after accept.
- Backpressure and back-to-back.
  - Hold res_ready=0 for 5 cycles in DONE. Expected: res_valid and results stable, cmd_ready=0, op_count unchanged.
  - Then raise res_ready with a second command pending on cmd_valid. Expected: accepted on the next IDLE cycle; its ra1=4 reads the value 8 written back by the previous command.
- Same destination. dst1=dst2=1, wb=1, out1=0xE, out2=3.
  - Expected: two writes issued; A[1]=3 afterwards.
- Reset mid-op. Assert rst asynchronously (between clock edges) during WB1.
  - Expected immediately: wr_en_a=0, cmd_ready=1, res_valid=0, op_count=0.
  - Expected: no WB2 write after reset deasserts.
- Counter wrap. Complete 256 operations with CNT_W=8.
  - Expected: op_count=0 after the 256th handshake; 255 just before it.
